// File: rtl/issue_scheduler.sv
// In-order issue scheduler: register/FU scoreboard, one-cycle issue strobe,
// halt-and-drain sequencing, and a saturating hazard stall counter.
module issue_scheduler #(
  parameter int NUM_FU = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0][4:0] in_readregs,
  input  logic [4:0]      in_writereg,
  input  logic [7:0]      in_flags,
  input  logic [3:0]      in_fuid,
  input  logic            in_halt,
  output logic            issue_valid,
  output logic [3:0]      issue_fuid,
  output logic [1:0][4:0] issue_readregs,
  output logic [4:0]      issue_writereg,
  output logic [7:0]      issue_flags,
  input  logic            wb_valid,
  input  logic [3:0]      wb_fuid,
  input  logic [4:0]      wb_reg,
  output logic [31:0]     pending_regs,
  output logic            halted,
  output logic [15:0]     stall_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Register 0 is hard-wired "no register", so its mask bit is always dropped.
  function automatic logic [31:0] reg_mask(input logic [4:0] r);
    return (32'd1 << r) & ~32'd1;
  endfunction

  function automatic logic [NUM_FU-1:0] fu_mask(input logic [3:0] id);
    logic [NUM_FU-1:0] m;
    for (int i = 0; i < NUM_FU; i++) begin
      m[i] = (int'(id) == i);
    end
    return m;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [31:0]       pending_r;
  logic [31:0]       pending_nxt_s;
  logic [31:0]       reg_set_s;
  logic [31:0]       reg_clr_s;
  logic [NUM_FU-1:0] fu_busy_r;
  logic [NUM_FU-1:0] fu_busy_nxt_s;
  logic [NUM_FU-1:0] fu_set_s;
  logic [NUM_FU-1:0] fu_clr_s;
  logic              hazard_free_s;
  logic              in_ready_s;
  logic              issue_fire_s;
  logic              halt_fire_s;
  logic              drained_s;
  logic              stall_inc_s;
  logic              issue_valid_r;
  logic [3:0]        issue_fuid_r;
  logic [1:0][4:0]   issue_readregs_r;
  logic [4:0]        issue_writereg_r;
  logic [7:0]        issue_flags_r;
  logic [15:0]       stall_r;

  // Hazard check looks only at registered scoreboard state; no writeback bypass.
  assign hazard_free_s = ~|(pending_r & (reg_mask(in_readregs[0]) |
                                         reg_mask(in_readregs[1]) |
                                         reg_mask(in_writereg))) &
                         ~|(fu_busy_r & fu_mask(in_fuid));
  assign in_ready_s    = ~rst & (state_r == ST_RUN) & (in_halt | hazard_free_s);
  assign issue_fire_s  = in_valid & in_ready_s & ~in_halt;
  assign halt_fire_s   = in_valid & in_ready_s & in_halt;
  assign drained_s     = (pending_r == 32'd0) && (fu_busy_r == {NUM_FU{1'b0}});
  assign stall_inc_s   = (state_r == ST_RUN) & in_valid & ~in_ready_s;

  // Clear first, then set, so a same-cycle issue beats a writeback.
  assign reg_clr_s     = wb_valid ? reg_mask(wb_reg) : 32'd0;
  assign reg_set_s     = issue_fire_s ? reg_mask(in_writereg) : 32'd0;
  assign fu_clr_s      = wb_valid ? fu_mask(wb_fuid) : {NUM_FU{1'b0}};
  assign fu_set_s      = issue_fire_s ? fu_mask(in_fuid) : {NUM_FU{1'b0}};
  assign pending_nxt_s = (pending_r & ~reg_clr_s) | reg_set_s;
  assign fu_busy_nxt_s = (fu_busy_r & ~fu_clr_s) | fu_set_s;

  // Run/drain/halted sequencing.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_fire_s) state_nxt_s = ST_DRAIN;
        else             state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (drained_s) state_nxt_s = ST_HALTED;
        else           state_nxt_s = ST_DRAIN;
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // State, scoreboard, issue register and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_RUN;
      pending_r        <= 32'd0;
      fu_busy_r        <= {NUM_FU{1'b0}};
      issue_valid_r    <= 1'b0;
      issue_fuid_r     <= 4'd0;
      issue_readregs_r <= 10'd0;
      issue_writereg_r <= 5'd0;
      issue_flags_r    <= 8'd0;
      stall_r          <= 16'd0;
    end else begin
      state_r       <= state_nxt_s;
      pending_r     <= pending_nxt_s & ~32'd1;
      fu_busy_r     <= fu_busy_nxt_s;
      issue_valid_r <= issue_fire_s;
      if (issue_fire_s) begin
        issue_fuid_r     <= in_fuid;
        issue_readregs_r <= in_readregs;
        issue_writereg_r <= in_writereg;
        issue_flags_r    <= in_flags;
      end
      if (stall_inc_s && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'd1;
      end
    end
  end

  assign in_ready       = in_ready_s;
  assign issue_valid    = issue_valid_r;
  assign issue_fuid     = issue_fuid_r;
  assign issue_readregs = issue_readregs_r;
  assign issue_writereg = issue_writereg_r;
  assign issue_flags    = issue_flags_r;
  assign pending_regs   = pending_r;
  assign halted         = (state_r == ST_HALTED);
  assign stall_count    = stall_r;

endmodule
